// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives the TMP8 adder for one cycle per command and captures the result into acc and flags.
// Defining ALU_OVF_FLAG_EN adds the signed-overflow output flag_v.
module alu_op_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_operand,
   output logic [WIDTH-1:0] adder_a,
   output logic [WIDTH-1:0] adder_b,
   output logic [1:0]       adder_mode,
   input  logic [WIDTH-1:0] adder_result,
   input  logic             adder_cb,
   output logic [WIDTH-1:0] acc,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_n,
`ifdef ALU_OVF_FLAG_EN
   output logic             flag_v,
`endif
   output logic             done
);
   localparam logic [2:0] OP_LDA = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_CMP = 3'b100;
   localparam logic [2:0] OP_INC = 3'b101;
   localparam logic [2:0] OP_DEC = 3'b110;
   localparam logic [2:0] OP_CLR = 3'b111;
   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] operand_q, operand_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             z_q, z_d, c_q, c_d, n_q, n_d;
   logic             is_add, is_sub, is_load;
   logic [WIDTH-1:0] load_val;
`ifdef ALU_OVF_FLAG_EN
   logic             v_q, v_d;
   assign flag_v = v_q;
`endif
   assign is_add   = (op_q == OP_ADD) || (op_q == OP_INC);
   assign is_sub   = (op_q == OP_SUB) || (op_q == OP_CMP) || (op_q == OP_DEC);
   assign is_load  = (op_q == OP_LDA) || (op_q == OP_CLR);
   assign load_val = (op_q == OP_LDA) ? operand_q : '0;
   assign acc      = acc_q;
   assign flag_z   = z_q;
   assign flag_c   = c_q;
   assign flag_n   = n_q;
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      operand_d  = operand_q;
      acc_d      = acc_q;
      z_d        = z_q;
      c_d        = c_q;
      n_d        = n_q;
`ifdef ALU_OVF_FLAG_EN
      v_d        = v_q;
`endif
      cmd_ready  = 1'b0;
      done       = 1'b0;
      adder_a    = '0;
      adder_b    = '0;
      adder_mode = 2'b00;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               op_d      = cmd_op;
               operand_d = cmd_operand;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            adder_a    = acc_q;
            adder_b    = ((op_q == OP_INC) || (op_q == OP_DEC)) ? WIDTH'(1) : (is_add || is_sub) ? operand_q : '0;
            adder_mode = is_add ? 2'b01 : is_sub ? 2'b10 : 2'b00;
            if (is_add || is_sub) begin
               acc_d = (op_q == OP_CMP) ? acc_q : adder_result;
               z_d   = (adder_result == '0);
               n_d   = adder_result[WIDTH-1];
               c_d   = adder_cb;
`ifdef ALU_OVF_FLAG_EN
               // Overflow when the effective operand signs agree but the result sign differs from a
               v_d   = (is_add ? (acc_q[WIDTH-1] == adder_b[WIDTH-1]) : (acc_q[WIDTH-1] != adder_b[WIDTH-1]))
                       && (adder_result[WIDTH-1] != acc_q[WIDTH-1]);
`endif
            end else if (is_load) begin
               acc_d = load_val;
               z_d   = (load_val == '0);
               n_d   = load_val[WIDTH-1];
`ifdef ALU_OVF_FLAG_EN
               v_d   = 1'b0;
`endif
            end
            state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         op_q      <= '0;
         operand_q <= '0;
         acc_q     <= '0;
         z_q       <= 1'b1;
         c_q       <= 1'b0;
         n_q       <= 1'b0;
`ifdef ALU_OVF_FLAG_EN
         v_q       <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         operand_q <= operand_d;
         acc_q     <= acc_d;
         z_q       <= z_d;
         c_q       <= c_d;
         n_q       <= n_d;
`ifdef ALU_OVF_FLAG_EN
         v_q       <= v_d;
`endif
      end
   end
endmodule
